izh_neuron_scheduler: RTL and testbench
=======================================

// Module: izh_neuron_scheduler
// PURPOSE
//   Time-multiplexes one shared Izhikevich update datapath (izh core) across N virtual neurons.
//   Holds each neuron's (v,u) state locally. On each timestep tick, issues one update per neuron
//   in index order and writes the results back. Publishes a per-step spike vector, a done pulse
//   and monitor taps. Sits between the top-level I/O wrapper and the izh datapath.
// PARAMETERS
//   N_NEURONS  4        number of virtual neurons (2..16); index width IW=$clog2(N_NEURONS)
//   VW         16       signed width of v, u and current
//   V_RESET    -16'sd65 reset value of every v register
//   U_RESET    -16'sd13 reset value of every u register
// PORTS
//   clk         in   1      clock, all logic on rising edge
//   reset       in   1      asynchronous, active-high reset
//   tick        in   1      one-cycle timestep strobe
//   clr_ovr     in   1      clears the overrun flag
//   cur_sel     out  IW     neuron index whose current is requested (combinational = idx)
//   cur_in      in   VW     signed stimulus current for neuron cur_sel
//   dp_valid    out  1      update request to datapath
//   dp_ready    in   1      datapath accepts request
//   dp_v        out  VW     v of neuron idx
//   dp_u        out  VW     u of neuron idx
//   dp_i        out  VW     current for neuron idx (= cur_in)
//   dp_res_vld  in   1      datapath result valid
//   dp_v_new    in   VW     updated v
//   dp_u_new    in   VW     updated u
//   dp_spike    in   1      neuron fired this step
//   spike_vec   out  N      spikes of last completed step, bit k = neuron k
//   spike_total out  16     saturating count of all spikes since reset
//   done        out  1      one-cycle pulse: step complete
//   busy        out  1      high in any state except IDLE
//   overrun     out  1      sticky: tick arrived while not IDLE
//   mon_sel     in   IW     monitor neuron select
//   mon_v       out  VW     stored v of neuron mon_sel (combinational read)
// BEHAVIOUR
//   Reset: state=IDLE, idx=0, all v=V_RESET, u=U_RESET, spike_vec=0, spike_acc=0,
//     spike_total=0, done=0, overrun=0, dp_valid=0. Reset mid-step aborts the step immediately.
//   FSM (registered state):
//     IDLE:  tick -> idx<=0, spike_acc<=0, ISSUE.
//     ISSUE: dp_valid=1, dp_v/dp_u/dp_i from regs[idx]/cur_in, stable until accepted.
//            dp_valid&dp_ready -> WAIT.
//     WAIT:  dp_valid=0; dp_res_vld -> regs[idx]<=(dp_v_new,dp_u_new), spike_acc[idx]<=dp_spike,
//            spike_total+=dp_spike (hold at 16'hFFFF). If idx==N-1: spike_vec<=acc with this
//            bit merged -> DONE; else idx<=idx+1 -> ISSUE.
//     DONE:  done=1 for exactly this cycle -> IDLE.
//   Latency: tick sampled in cycle 0; neuron k issued in cycle 1+2k when ready=1 and result
//     returns the cycle after acceptance; done in cycle 2N+1. A stalled ready or late result
//     extends the step by the stall length. No timeout.
//   dp_res_vld outside WAIT is ignored. Only one request is outstanding at a time.
//   tick in any state other than IDLE (including DONE) is dropped and sets overrun. overrun
//     clears on clr_ovr. Simultaneous set and clear: set wins.
//   spike_vec changes only on entry to DONE; it holds the previous step's value during a step.
//   v/u values are passed through unmodified (signed, no arithmetic); idx wraps only via IDLE.
//   mon_v reflects a write-back on the cycle after the write.
// TESTING
//   1 Reset, N=4: spike_vec=0, busy=0, mon_v=-65 for every mon_sel; dp_valid=0.
//   2 tick, ready=1, result 1 cycle later, dp_spike=1 on neuron 2 only -> done in cycle 9,
//     spike_vec=4'b0100, spike_total=1.
//   3 dp_ready low 3 cycles on neuron 1 -> dp_v/u/i held stable, done in cycle 12.
//   4 tick during step and in DONE cycle -> overrun=1, no second step; clr_ovr -> overrun=0.
//   5 Return dp_v_new=-30 for neuron 3 -> mon_sel=3 gives mon_v=-30; next step dp_v=-30 for idx 3.
//   6 Assert reset during WAIT of neuron 1 -> IDLE, busy=0, v/u back to reset, no done pulse.

Source files
------------

// File: rtl/izh_neuron_scheduler.sv
// izh_neuron_scheduler: time-multiplexes one shared Izhikevich datapath across N_NEURONS virtual neurons.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   tick, clr_ovr       timestep strobe, overrun flag clear
//   cur_sel, cur_in     current request index (= idx) and the returned signed current
//   dp_valid/dp_ready   request handshake; dp_v/dp_u/dp_i carry neuron idx state and current
//   dp_res_vld          result strobe with dp_v_new/dp_u_new/dp_spike
//   spike_vec           spikes of the last completed step; spike_total saturating spike count
//   done, busy, overrun step-complete pulse, not-idle, sticky dropped-tick flag
//   mon_sel, mon_v      combinational read of a stored v
module izh_neuron_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int VW = 16,
    parameter logic signed [VW-1:0] V_RESET = -16'sd65,
    parameter logic signed [VW-1:0] U_RESET = -16'sd13,
    localparam int IW = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 clr_ovr,
    output logic [IW-1:0]        cur_sel,
    input  logic [VW-1:0]        cur_in,
    output logic                 dp_valid,
    input  logic                 dp_ready,
    output logic [VW-1:0]        dp_v,
    output logic [VW-1:0]        dp_u,
    output logic [VW-1:0]        dp_i,
    input  logic                 dp_res_vld,
    input  logic [VW-1:0]        dp_v_new,
    input  logic [VW-1:0]        dp_u_new,
    input  logic                 dp_spike,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic [15:0]          spike_total,
    output logic                 done,
    output logic                 busy,
    output logic                 overrun,
    input  logic [IW-1:0]        mon_sel,
    output logic [VW-1:0]        mon_v
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0]        idx;
    logic [N_NEURONS-1:0] spike_acc, acc_upd;
    logic [VW-1:0]        v_mem [N_NEURONS];
    logic [VW-1:0]        u_mem [N_NEURONS];
    logic                 last, wr;

    assign last    = idx == IW'(N_NEURONS - 1);
    assign wr      = state == S_WAIT && dp_res_vld;
    assign cur_sel = idx;
    assign dp_v    = v_mem[idx];
    assign dp_u    = u_mem[idx];
    assign dp_i    = cur_in;
    assign mon_v   = v_mem[mon_sel];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        dp_valid  = state == S_ISSUE;
        done      = state == S_DONE;
        busy      = state != S_IDLE;
        unique case (state)
            S_IDLE:  state_nxt = tick ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nxt = dp_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  state_nxt = dp_res_vld ? (last ? S_DONE : S_ISSUE) : S_WAIT;
            S_DONE:  state_nxt = S_IDLE;
        endcase
    end

    // Accumulated spikes with the current neuron's result merged in, so the
    // final write-back can publish the complete vector in the same cycle.
    always_comb begin
        acc_upd      = spike_acc;
        acc_upd[idx] = dp_spike;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            spike_acc   <= '0;
            spike_vec   <= '0;
            spike_total <= '0;
            overrun     <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V_RESET;
                u_mem[k] <= U_RESET;
            end
        end else begin
            overrun <= (tick && state != S_IDLE) ? 1'b1 : (clr_ovr ? 1'b0 : overrun);
            if (state == S_IDLE && tick) begin
                idx       <= '0;
                spike_acc <= '0;
            end
            if (wr) begin
                v_mem[idx] <= dp_v_new;
                u_mem[idx] <= dp_u_new;
                spike_acc  <= acc_upd;
                if (dp_spike && spike_total != 16'hFFFF) spike_total <= spike_total + 16'd1;
                if (last) spike_vec <= acc_upd;
                else      idx       <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// tb_izh_neuron_scheduler: randomized self-checking bench acting as the izh datapath against a neuron-state model.
module tb_izh_neuron_scheduler;
    localparam int N = 4;
    logic               clk = 1'b0;
    logic               reset, tick, clr_ovr, dp_ready, dp_res_vld, dp_spike;
    logic [1:0]         cur_sel, mon_sel;
    logic signed [15:0] cur_in, dp_v, dp_u, dp_i, dp_v_new, dp_u_new, mon_v;
    logic               dp_valid, done, busy, overrun;
    logic [N-1:0]       spike_vec;
    logic [15:0]        spike_total;
    logic signed [15:0] cur_tab [N];
    logic signed [15:0] mv [N];
    logic signed [15:0] mu [N];
    logic [N-1:0]       vec_m;
    int                 tot_m;
    int                 n_chk = 0;
    int                 n_fail = 0;

    izh_neuron_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .clr_ovr(clr_ovr),
        .cur_sel(cur_sel), .cur_in(cur_in),
        .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_res_vld(dp_res_vld), .dp_v_new(dp_v_new), .dp_u_new(dp_u_new), .dp_spike(dp_spike),
        .spike_vec(spike_vec), .spike_total(spike_total),
        .done(done), .busy(busy), .overrun(overrun),
        .mon_sel(mon_sel), .mon_v(mon_v)
    );

    always #5 clk = ~clk;
    assign cur_in = cur_tab[cur_sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int k = 0; k < N; k++) begin
            mv[k] = -16'sd65;
            mu[k] = -16'sd13;
        end
        vec_m = '0;
        tot_m = 0;
    endtask

    // One full timestep: the bench plays the datapath. sk/sl stall neuron sk's
    // acceptance for sl cycles; ovr: 1 tick in a WAIT, 2 tick in DONE,
    // 3 tick together with clr_ovr in a WAIT.
    task automatic run_step(input int sk, input int sl, input logic [N-1:0] spk,
                            input bit force3, input int ovr);
        logic signed [15:0] nv, nu;
        for (int k = 0; k < N; k++) cur_tab[k] = 16'($urandom);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == sk) begin
                for (int s = 0; s < sl; s++) begin
                    dp_ready   = 1'b0;
                    dp_res_vld = 1'b1;
                    dp_v_new   = 16'($urandom);
                    dp_spike   = 1'b1;
                    chk("stall_valid", dp_valid, 1);
                    chk("stall_v", dp_v, mv[k]);
                    chk("stall_u", dp_u, mu[k]);
                    chk("stall_i", dp_i, cur_tab[k]);
                    cyc();
                end
            end
            dp_ready   = 1'b1;
            dp_res_vld = 1'b0;
            chk("issue_valid", dp_valid, 1);
            chk("issue_sel", cur_sel, k);
            chk("issue_v", dp_v, mv[k]);
            chk("issue_u", dp_u, mu[k]);
            chk("issue_i", dp_i, cur_tab[k]);
            chk("issue_busy", busy, 1);
            chk("issue_done", done, 0);
            chk("hold_vec", spike_vec, vec_m);
            nv = (force3 && k == 3) ? -16'sd30 : 16'($urandom);
            nu = 16'($urandom);
            cyc();
            chk("wait_valid", dp_valid, 0);
            if (ovr != 2 && ovr != 0 && k == 1) tick = 1'b1;
            clr_ovr    = (ovr == 3 && k == 1);
            dp_ready   = 1'b0;
            dp_res_vld = 1'b1;
            dp_v_new   = nv;
            dp_u_new   = nu;
            dp_spike   = spk[k];
            mon_sel    = 2'(k);
            cyc();
            tick       = 1'b0;
            clr_ovr    = 1'b0;
            dp_res_vld = 1'b0;
            mv[k] = nv;
            mu[k] = nu;
            if (spk[k] && tot_m < 65535) tot_m++;
            chk("mon_v", mon_v, mv[k]);
        end
        vec_m = spk;
        chk("done", done, 1);
        chk("spike_vec", spike_vec, vec_m);
        chk("spike_total", spike_total, tot_m);
        if (ovr == 2) tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        if (ovr != 0) begin
            cyc();
            chk("no_restep", busy, 0);
            chk("overrun_set", overrun, 1);
        end
    endtask

    task automatic clear_ovr();
        clr_ovr = 1'b1;
        cyc();
        clr_ovr = 1'b0;
        chk("overrun_clr", overrun, 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; clr_ovr = 1'b0; dp_ready = 1'b0; dp_res_vld = 1'b0;
        dp_spike = 1'b0; dp_v_new = '0; dp_u_new = '0; mon_sel = '0;
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        reset_model();
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_vec", spike_vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", dp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_total", spike_total, 0);
        for (int s = 0; s < N; s++) begin
            mon_sel = 2'(s);
            #1;
            chk("rst_mon_v", mon_v, -16'sd65);
        end
        run_step(-1, 0, 4'b0100, 1'b0, 0);
        run_step(1, 3, 4'($urandom), 1'b0, 0);
        run_step(-1, 0, 4'($urandom), 1'b0, 1);
        clear_ovr();
        run_step(-1, 0, 4'($urandom), 1'b0, 2);
        clear_ovr();
        run_step(-1, 0, 4'($urandom), 1'b0, 3);
        clear_ovr();
        run_step(-1, 0, 4'($urandom), 1'b1, 0);
        run_step(-1, 0, 4'($urandom), 1'b0, 0);
        for (int r = 0; r < 20; r++)
            run_step(int'($urandom_range(0, N)), int'($urandom_range(0, 4)), 4'($urandom), 1'b0, 0);
        chk("no_ovr_random", overrun, 0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        dp_ready = 1'b1;
        cyc();
        dp_ready = 1'b0;
        dp_res_vld = 1'b1;
        dp_v_new = 16'sd123;
        dp_u_new = 16'sd45;
        dp_spike = 1'b1;
        cyc();
        dp_res_vld = 1'b0;
        dp_ready = 1'b1;
        cyc();
        dp_ready = 1'b0;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", dp_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_total", spike_total, 0);
        chk("abort_vec", spike_vec, 0);
        for (int s = 0; s < N; s++) begin
            mon_sel = 2'(s);
            #1;
            chk("abort_mon_v", mon_v, -16'sd65);
        end
        reset = 1'b0;
        reset_model();
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
        end
        run_step(-1, 0, 4'b1011, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
